// File: rtl/source_config.sv
//-----------------------------------------------------------------------------
// Package     : source_config
// Description : Shared sizing for the source packet path. SRC_BYTES is the
//               number of stream bytes per packet and SRC_PAD the number of
//               unused MSBs in the first (most significant) byte.
//               `SRC_WIDTH defaults to 12 when the build does not supply it.
// Revision    : 1.0 - initial release
//-----------------------------------------------------------------------------
`default_nettype none

`ifndef SRC_WIDTH
`define SRC_WIDTH 12
`endif

package source_config;

  localparam int SRC_BYTES = (`SRC_WIDTH + 7) / 8;
  localparam int SRC_PAD   = 8 * SRC_BYTES - `SRC_WIDTH;

  // Byte counter width; counts 0..SRC_BYTES-1.
  localparam int SRC_CNT_W = $clog2(SRC_BYTES + 1);

endpackage : source_config

`default_nettype wire

// File: rtl/source_packet_assembler.sv
//-----------------------------------------------------------------------------
// Module      : source_packet_assembler
// Description : Packs a valid/ready byte stream, big-endian, into `SRC_WIDTH
//               bit packets for network_source. One registered output slot
//               lets the next packet assemble while the current one is held.
//               Packets are passed through opaquely (no opcode decode).
// Revision    : 1.0 - initial release
//
// Build option: SRC_ASM_TIMEOUT_EN
//   defined   - a partial packet idle for TIMEOUT_CYCLES cycles is dropped
//               and asm_timeout pulses for one cycle.
//   undefined - a partial packet waits indefinitely; asm_timeout is 0.
//
// Ports
//   clk          in   1           clock, rising edge
//   arstn        in   1           asynchronous reset, active-low
//   byte_valid   in   1           upstream byte valid
//   byte_ready   out  1           byte accepted when byte_valid && byte_ready
//   byte_data    in   8           upstream byte
//   src_valid    out  1           packet valid
//   src_ready    in   1           downstream ready
//   src          out  `SRC_WIDTH  assembled packet
//   asm_timeout  out  1           1-cycle pulse when a partial packet is dropped
//-----------------------------------------------------------------------------
`default_nettype none

module source_packet_assembler
  import source_config::*;
#(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                  clk,
  input  logic                  arstn,
  input  logic                  byte_valid,
  output logic                  byte_ready,
  input  logic [7:0]            byte_data,
  output logic                  src_valid,
  input  logic                  src_ready,
  output logic [`SRC_WIDTH-1:0] src,
  output logic                  asm_timeout
);

  localparam int SRC_W = `SRC_WIDTH;
  localparam int ASM_W = SRC_W + SRC_PAD;  // 8 * SRC_BYTES
  localparam logic [SRC_CNT_W-1:0] LAST_IDX = SRC_CNT_W'(SRC_BYTES - 1);

  logic [SRC_CNT_W-1:0] byte_cnt;
  logic [ASM_W-1:0]     shift_reg;
  logic                 last_byte;
  logic                 byte_hs;
  logic                 expire;

  assign last_byte = (byte_cnt == LAST_IDX);

  // Only the final byte can stall: it needs the output slot to be free or
  // draining this cycle. Non-final bytes go into the shift register freely.
  assign byte_ready = !(last_byte && src_valid && !src_ready);
  assign byte_hs    = byte_valid && byte_ready;

  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      byte_cnt  <= '0;
      shift_reg <= '0;
      src       <= '0;
      src_valid <= 1'b0;
    end else begin
      // Output drains on handshake; a final byte in the same cycle refills it.
      if (src_valid && src_ready) begin
        src_valid <= 1'b0;
      end

      if (byte_hs) begin
        if (last_byte) begin
          // Truncation to SRC_W drops the pad MSBs of the first byte.
          src       <= SRC_W'({shift_reg, byte_data});
          src_valid <= 1'b1;
          byte_cnt  <= '0;
          shift_reg <= '0;
        end else begin
          shift_reg <= ASM_W'({shift_reg, byte_data});
          byte_cnt  <= byte_cnt + 1'b1;
        end
      end else if (expire) begin
        byte_cnt  <= '0;
        shift_reg <= '0;
      end
    end
  end

`ifdef SRC_ASM_TIMEOUT_EN
  localparam int IDLE_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT_CYCLES - 1);

  logic [IDLE_W-1:0] idle_cnt;

  // Expiry is the TIMEOUT_CYCLES-th consecutive idle cycle mid-packet;
  // a byte handshake in that cycle takes priority.
  assign expire = (byte_cnt != '0) && !byte_hs && (idle_cnt == IDLE_LAST);

  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      idle_cnt    <= '0;
      asm_timeout <= 1'b0;
    end else begin
      asm_timeout <= expire;
      if (byte_hs || (byte_cnt == '0) || expire) begin
        idle_cnt <= '0;
      end else begin
        idle_cnt <= idle_cnt + 1'b1;
      end
    end
  end
`else
  // TIMEOUT_CYCLES has no effect in this build; the compare folds to 0.
  assign expire      = (TIMEOUT_CYCLES < 0);
  assign asm_timeout = 1'b0;
`endif

endmodule : source_packet_assembler

`default_nettype wire

// File: tb/tb_source_packet_assembler.sv
//-----------------------------------------------------------------------------
// Module      : tb_source_packet_assembler
// Description : Self-checking bench for source_packet_assembler. A queue
//               based reference model tracks the pending bytes and the
//               output slot; directed scenarios and a randomized run are
//               compared against it cycle by cycle.
// Revision    : 1.0 - initial release
//-----------------------------------------------------------------------------
`default_nettype none

`ifndef SRC_WIDTH
`define SRC_WIDTH 12
`endif

module tb_source_packet_assembler;
  import source_config::*;

  localparam int W   = `SRC_WIDTH;
  localparam int TMO = 8;

  logic         clk = 1'b0;
  logic         arstn = 1'b0;
  logic         byte_valid = 1'b0;
  logic [7:0]   byte_data = 8'h00;
  logic         src_ready = 1'b0;
  logic         byte_ready;
  logic         src_valid;
  logic [W-1:0] src;
  logic         asm_timeout;

  always #5 clk = ~clk;

  source_packet_assembler #(
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk        (clk),
    .arstn      (arstn),
    .byte_valid (byte_valid),
    .byte_ready (byte_ready),
    .byte_data  (byte_data),
    .src_valid  (src_valid),
    .src_ready  (src_ready),
    .src        (src),
    .asm_timeout(asm_timeout)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model state
  logic [7:0]   m_pend[$];
  bit           m_held;
  logic [W-1:0] m_pkt;
  bit           m_to;
  int           m_idle;

  // Observed / expected values of the last tick (sampled before the edge)
  logic         obs_ready, obs_valid, obs_to;
  logic [W-1:0] obs_src;
  logic         exp_ready, exp_valid, exp_to;
  logic [W-1:0] exp_src;

  function automatic void model_reset();
    m_pend.delete();
    m_held = 1'b0;
    m_pkt  = '0;
    m_to   = 1'b0;
    m_idle = 0;
  endfunction

  function automatic logic [W-1:0] pack_pending();
    logic [8*SRC_BYTES-1:0] v;
    v = '0;
    foreach (m_pend[i]) v = (v << 8) | {{(8*SRC_BYTES-8){1'b0}}, m_pend[i]};
    return v[W-1:0];
  endfunction

  function automatic bit model_ready(input logic sr);
    return !((m_pend.size() == SRC_BYTES - 1) && m_held && !sr);
  endfunction

  // One clock: drive inputs, sample outputs at negedge, advance model at posedge.
  task automatic tick(input logic bv, input logic [7:0] bd, input logic sr);
    bit hs;
    byte_valid = bv;
    byte_data  = bd;
    src_ready  = sr;
    @(negedge clk);
    obs_ready = byte_ready;
    obs_valid = src_valid;
    obs_src   = src;
    obs_to    = asm_timeout;
    exp_ready = model_ready(sr);
    exp_valid = m_held;
    exp_src   = m_pkt;
    exp_to    = m_to;
    @(posedge clk);
    hs   = bv && exp_ready;
    m_to = 1'b0;
    if (m_held && sr) m_held = 1'b0;
    if (hs) begin
      m_pend.push_back(bd);
      m_idle = 0;
      if (m_pend.size() == SRC_BYTES) begin
        m_pkt  = pack_pending();
        m_held = 1'b1;
        m_pend.delete();
      end
    end
`ifdef SRC_ASM_TIMEOUT_EN
    else if (m_pend.size() != 0) begin
      m_idle++;
      if (m_idle == TMO) begin
        m_pend.delete();
        m_idle = 0;
        m_to   = 1'b1;
      end
    end
`endif
    #1;
  endtask

  task automatic test_reset();
    arstn = 1'b0;
    byte_valid = 1'b0;
    src_ready = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    n_checks++;
    if (src_valid !== 1'b0) $display("FAIL reset_src_valid actual=%b required=0", src_valid);
    else n_pass++;
    n_checks++;
    if (src !== '0) $display("FAIL reset_src actual=%h required=0", src);
    else n_pass++;
    n_checks++;
    if (asm_timeout !== 1'b0) $display("FAIL reset_asm_timeout actual=%b required=0", asm_timeout);
    else n_pass++;
    n_checks++;
    if (byte_ready !== 1'b1) $display("FAIL reset_byte_ready actual=%b required=1", byte_ready);
    else n_pass++;
    @(posedge clk);
    #1 arstn = 1'b1;
  endtask

  task automatic test_basic();
    tick(1'b1, 8'h0B, 1'b1);
    tick(1'b1, 8'h05, 1'b1);
    tick(1'b0, 8'h00, 1'b1);
    n_checks++;
    if ({obs_valid, obs_src} !== {1'b1, 12'hB05})
      $display("FAIL basic_packet actual=%b/%h required=1/b05", obs_valid, obs_src);
    else n_pass++;
    tick(1'b0, 8'h00, 1'b1);
    n_checks++;
    if ({obs_valid, obs_src} !== {1'b0, 12'hB05})
      $display("FAIL basic_one_cycle actual=%b/%h required=0/b05", obs_valid, obs_src);
    else n_pass++;
  endtask

  task automatic test_pad();
    tick(1'b1, 8'hFB, 1'b1);
    tick(1'b1, 8'h05, 1'b1);
    tick(1'b0, 8'h00, 1'b1);
    n_checks++;
    if ({obs_valid, obs_src} !== {1'b1, 12'hB05})
      $display("FAIL pad_ignored actual=%b/%h required=1/b05", obs_valid, obs_src);
    else n_pass++;
    tick(1'b0, 8'h00, 1'b1);
  endtask

  task automatic test_backpressure();
    tick(1'b1, 8'h04, 1'b0);
    tick(1'b1, 8'h0A, 1'b0);
    tick(1'b1, 8'h0B, 1'b0);
    n_checks++;
    if ({obs_ready, obs_valid, obs_src} !== {1'b1, 1'b1, 12'h40A})
      $display("FAIL bp_nonfinal_accept actual=%b/%b/%h required=1/1/40a", obs_ready, obs_valid, obs_src);
    else n_pass++;
    for (int i = 0; i < 3; i++) begin
      tick(1'b1, 8'h05, 1'b0);
      n_checks++;
      if ({obs_ready, obs_valid, obs_src} !== {1'b0, 1'b1, 12'h40A})
        $display("FAIL bp_final_stall actual=%b/%b/%h required=0/1/40a", obs_ready, obs_valid, obs_src);
      else n_pass++;
    end
    tick(1'b1, 8'h05, 1'b1);
    n_checks++;
    if ({obs_ready, obs_valid, obs_src} !== {1'b1, 1'b1, 12'h40A})
      $display("FAIL bp_release actual=%b/%b/%h required=1/1/40a", obs_ready, obs_valid, obs_src);
    else n_pass++;
    tick(1'b0, 8'h00, 1'b1);
    n_checks++;
    if ({obs_valid, obs_src} !== {1'b1, 12'hB05})
      $display("FAIL bp_next_packet actual=%b/%h required=1/b05", obs_valid, obs_src);
    else n_pass++;
    tick(1'b0, 8'h00, 1'b1);
    n_checks++;
    if (obs_valid !== 1'b0) $display("FAIL bp_no_duplicate actual=%b required=0", obs_valid);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    int nvalid;
    nvalid = 0;
    for (int i = 0; i < 9; i++) begin
      tick(i < 8, 8'($urandom), 1'b1);
      if (obs_valid === 1'b1) nvalid++;
      n_checks++;
      if ({obs_ready, obs_valid, obs_src} !== {1'b1, exp_valid, exp_src})
        $display("FAIL b2b_cycle%0d actual=%b/%b/%h required=1/%b/%h",
                 i, obs_ready, obs_valid, obs_src, exp_valid, exp_src);
      else n_pass++;
    end
    n_checks++;
    if (nvalid != 4) $display("FAIL b2b_packet_count actual=%0d required=4", nvalid);
    else n_pass++;
    tick(1'b0, 8'h00, 1'b1);
  endtask

  task automatic test_reset_mid();
    tick(1'b1, 8'h04, 1'b0);
    tick(1'b1, 8'h0A, 1'b0);
    tick(1'b1, 8'h0B, 1'b0);
    byte_valid = 1'b0;
    #1 arstn = 1'b0;
    model_reset();
    #2;
    n_checks++;
    if ({src_valid, src} !== {1'b0, {W{1'b0}}})
      $display("FAIL midreset_clear actual=%b/%h required=0/000", src_valid, src);
    else n_pass++;
    @(negedge clk);
    arstn = 1'b1;
    @(posedge clk);
    #1;
    tick(1'b1, 8'h0B, 1'b1);
    tick(1'b1, 8'h05, 1'b1);
    tick(1'b0, 8'h00, 1'b1);
    n_checks++;
    if ({obs_valid, obs_src} !== {1'b1, 12'hB05})
      $display("FAIL midreset_packet actual=%b/%h required=1/b05", obs_valid, obs_src);
    else n_pass++;
    tick(1'b0, 8'h00, 1'b1);
    n_checks++;
    if (obs_valid !== 1'b0) $display("FAIL midreset_single actual=%b required=0", obs_valid);
    else n_pass++;
  endtask

  task automatic test_idle();
`ifdef SRC_ASM_TIMEOUT_EN
    tick(1'b1, 8'h0B, 1'b1);
    for (int i = 0; i < TMO; i++) begin
      tick(1'b0, 8'h00, 1'b1);
      n_checks++;
      if (obs_to !== 1'b0) $display("FAIL tmo_early idle=%0d actual=%b required=0", i, obs_to);
      else n_pass++;
    end
    tick(1'b0, 8'h00, 1'b1);
    n_checks++;
    if (obs_to !== 1'b1) $display("FAIL tmo_pulse actual=%b required=1", obs_to);
    else n_pass++;
    tick(1'b1, 8'h04, 1'b1);
    n_checks++;
    if (obs_to !== 1'b0) $display("FAIL tmo_pulse_width actual=%b required=0", obs_to);
    else n_pass++;
    tick(1'b1, 8'h0A, 1'b1);
    tick(1'b0, 8'h00, 1'b1);
    n_checks++;
    if ({obs_valid, obs_src} !== {1'b1, 12'h40A})
      $display("FAIL tmo_after_drop actual=%b/%h required=1/40a", obs_valid, obs_src);
    else n_pass++;
    tick(1'b1, 8'h0B, 1'b1);
    repeat (TMO - 1) tick(1'b0, 8'h00, 1'b1);
    tick(1'b1, 8'h05, 1'b1);
    tick(1'b0, 8'h00, 1'b1);
    n_checks++;
    if ({obs_valid, obs_src, obs_to} !== {1'b1, 12'hB05, 1'b0})
      $display("FAIL tmo_byte_wins actual=%b/%h/%b required=1/b05/0", obs_valid, obs_src, obs_to);
    else n_pass++;
    tick(1'b0, 8'h00, 1'b1);
`else
    tick(1'b1, 8'h0B, 1'b1);
    for (int i = 0; i < 20; i++) begin
      tick(1'b0, 8'h00, 1'b1);
      n_checks++;
      if ({obs_to, obs_valid} !== 2'b00)
        $display("FAIL idle_wait%0d actual=%b/%b required=0/0", i, obs_to, obs_valid);
      else n_pass++;
    end
    tick(1'b1, 8'h05, 1'b1);
    tick(1'b0, 8'h00, 1'b1);
    n_checks++;
    if ({obs_valid, obs_src} !== {1'b1, 12'hB05})
      $display("FAIL idle_resume actual=%b/%h required=1/b05", obs_valid, obs_src);
    else n_pass++;
    tick(1'b0, 8'h00, 1'b1);
`endif
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      tick(($urandom % 4) != 0, 8'($urandom), ($urandom % 3) != 0);
      n_checks++;
      if ({obs_ready, obs_valid, obs_src, obs_to} !== {exp_ready, exp_valid, exp_src, exp_to})
        $display("FAIL random_cycle%0d actual=%b/%b/%h/%b required=%b/%b/%h/%b",
                 i, obs_ready, obs_valid, obs_src, obs_to,
                 exp_ready, exp_valid, exp_src, exp_to);
      else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_pad();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    test_idle();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule : tb_source_packet_assembler

`default_nettype wire
